// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  // Controller states: wait for start, shift one bit per clock, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Full adder slice built from two half adders and an OR for the carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (sum),
    .c (c1)
  );

  // At most one half adder can generate a carry, so OR merges them.
  always_comb begin
    cout = c0 | c1;
  end

endmodule

// File: rtl/half_adder.sv
// Half adder cell: one-bit sum and carry of two inputs.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Purely combinational sum/carry.
  always_comb begin
    s = a ^ b;
    c = a & b;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: adds two WIDTH-bit operands LSB first, one bit per
// clock, through a single full-adder slice and a registered carry.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state, start acceptance and status outputs.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    last_bit = (cnt == LAST);
    busy     = (state == RUN);
    done     = (state == DONE);
    // Result register shifts right with the new bit entering at the MSB;
    // only WIDTH-1 bits are stored since the final bit goes straight to sum.
    acc_next = {fa_s, acc};
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_n = RUN;
      end
      RUN: begin
        if (last_bit) state_n = DONE;
      end
      DONE: begin
        accept  = start;
        state_n = start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand shifting, carry chain, bit counter and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      acc   <= acc_next[WIDTH-1:1];
      if (last_bit) begin
        sum  <= acc_next;
        cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
        // carry still holds the carry into the MSB slice on this edge.
        ovf  <= carry ^ fa_c;
`endif
      end
    end
  end

endmodule
